// File: rtl/fetch_pc_gen.sv
// Fetch-address stage: owns the fetch PC, arbitrates prioritised redirects and BTB predictions,
// and queues aligned fetch groups for the I-cache side.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int          FETCH_WIDTH = 2,
  parameter int          NUM_REDIR   = 3,
  parameter int          QUEUE_DEPTH = 4,
  localparam int         LANE_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic [NUM_REDIR-1:0]   redir_valid,
  input  logic [32*NUM_REDIR-1:0] redir_pc,
  input  logic [NUM_REDIR-1:0]   redir_is_pred,
  output logic [31:0]            btb_pc,
  output logic                   btb_stall,
  input  logic                   btb_valid,
  input  logic [31:0]            btb_npc,
  input  logic [LANE_W-1:0]      btb_lane,
  output logic                   req_valid,
  output logic [31:0]            req_pc,
  output logic [FETCH_WIDTH-1:0] req_mask,
  output logic                   req_is_pred,
  output logic                   req_adef,
  input  logic                   req_ready
);

  localparam int          PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int          ENT_W       = 32 + FETCH_WIDTH + 2;
  localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               is_pred_q, is_pred_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [ENT_W-1:0]   q_mem [QUEUE_DEPTH];

  logic               redirect, gen_fire, deq, enq, full, adef, taken;
  logic [31:0]        win_pc, base, seq_npc, next_pc;
  logic               win_pred;
  logic [LANE_W-1:0]  off;
  logic [FETCH_WIDTH-1:0] lane_mask;
  logic [ENT_W-1:0]   enq_ent, head_ent;

  // Lowest index wins: scan from the top so lower indices overwrite.
  always_comb begin
    win_pc   = '0;
    win_pred = 1'b0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        win_pc   = redir_pc[32*i +: 32];
        win_pred = redir_is_pred[i];
      end
    end
  end

  assign redirect = rst_n & (|redir_valid);
  assign full     = (count_q == (PTR_W+1)'(QUEUE_DEPTH));
  assign req_valid = (count_q != '0);
  assign deq      = req_valid & req_ready;
  assign gen_fire = rst_n & (state_q == S_RUN) & ~stall_i & (~full | deq);

  assign adef  = (pc_q[1:0] != 2'b00);
  assign off   = (FETCH_WIDTH > 1) ? pc_q[2 +: LANE_W] : '0;
  assign base  = pc_q & ~(GROUP_BYTES - 32'd1);
  // A predicted lane before the group's first valid lane belongs to an earlier group.
  assign taken = btb_valid & (btb_lane >= off) & ~adef;
  assign seq_npc = taken ? btb_npc : base + GROUP_BYTES;
  assign next_pc = adef ? pc_q : seq_npc;

  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
    localparam logic [LANE_W-1:0] IDX = LANE_W'(gi);
    assign lane_mask[gi] = (IDX >= off) & (~taken | (IDX <= btb_lane));
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    is_pred_d = is_pred_q;
    enq       = 1'b0;
    enq_ent   = {pc_q, lane_mask, is_pred_q, 1'b0};
    if (redirect) begin
      pc_d      = win_pc;
      is_pred_d = win_pred;
      state_d   = S_RUN;
    end else if (gen_fire) begin
      enq = 1'b1;
      if (adef) begin
        enq_ent = {pc_q, {FETCH_WIDTH{1'b0}}, is_pred_q, 1'b1};
        state_d = S_HALT;
      end else begin
        pc_d      = seq_npc;
        is_pred_d = taken;
      end
    end
  end

  assign btb_pc    = redirect ? win_pc : (gen_fire ? next_pc : pc_q);
  assign btb_stall = ~gen_fire & ~redirect;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      is_pred_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      is_pred_q <= is_pred_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) q_mem[wr_ptr_q] <= enq_ent;
  end

  // Head fields are forced to zero when empty so stale storage never leaks out.
  assign head_ent = req_valid ? q_mem[rd_ptr_q] : '0;
  assign {req_pc, req_mask, req_is_pred, req_adef} = head_ent;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus a randomized run against a
// transaction-level model of the PC generator and its request queue.
module tb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int FW = 2;
  localparam int NR = 3;
  localparam int QD = 4;
  localparam int LANE_W = (FW > 1) ? $clog2(FW) : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              stall_i;
  logic [NR-1:0]     redir_valid;
  logic [32*NR-1:0]  redir_pc;
  logic [NR-1:0]     redir_is_pred;
  logic [31:0]       btb_pc;
  logic              btb_stall;
  logic              btb_valid;
  logic [31:0]       btb_npc;
  logic [LANE_W-1:0] btb_lane;
  logic              req_valid;
  logic [31:0]       req_pc;
  logic [FW-1:0]     req_mask;
  logic              req_is_pred;
  logic              req_adef;
  logic              req_ready;

  fetch_pc_gen #(.RESET_PC(RESET_PC), .FETCH_WIDTH(FW), .NUM_REDIR(NR), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_is_pred(redir_is_pred),
    .btb_pc(btb_pc), .btb_stall(btb_stall), .btb_valid(btb_valid),
    .btb_npc(btb_npc), .btb_lane(btb_lane),
    .req_valid(req_valid), .req_pc(req_pc), .req_mask(req_mask),
    .req_is_pred(req_is_pred), .req_adef(req_adef), .req_ready(req_ready)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0]   pc;
    logic [FW-1:0] mask;
    logic          pred;
    logic          adef;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_pred;
  bit          m_halt;

  // Per-cycle decisions of the model, computed from current inputs
  bit          c_red, c_deq, c_fire;
  logic [31:0] c_win_pc, c_next_pc;
  logic        c_win_pred, c_next_pred;
  ent_t        c_ent;
  logic [31:0] exp_btb_pc;
  logic        exp_btb_stall;

  task automatic model_reset();
    m_q.delete();
    m_pc   = RESET_PC;
    m_pred = 1'b0;
    m_halt = 0;
  endtask

  task automatic model_comb();
    int off;
    logic [31:0] base;
    bit taken;
    c_red = 0;
    c_win_pc = '0;
    c_win_pred = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (!c_red && redir_valid[i]) begin
        c_red = 1;
        c_win_pc = redir_pc[32*i +: 32];
        c_win_pred = redir_is_pred[i];
      end
    end
    c_deq  = (m_q.size() > 0) && req_ready;
    c_fire = !m_halt && !stall_i && ((m_q.size() < QD) || c_deq);
    c_ent.pc   = m_pc;
    c_ent.pred = m_pred;
    c_ent.adef = 1'b0;
    c_ent.mask = '0;
    c_next_pc   = m_pc;
    c_next_pred = m_pred;
    if (m_pc % 4 != 0) begin
      c_ent.adef = 1'b1;
    end else begin
      off   = int'((m_pc / 4) % FW);
      base  = m_pc - (m_pc % (FW * 4));
      taken = btb_valid && (int'(btb_lane) >= off);
      for (int i = 0; i < FW; i++)
        c_ent.mask[i] = (i >= off) && (!taken || i <= int'(btb_lane));
      c_next_pc   = taken ? btb_npc : base + 32'(FW * 4);
      c_next_pred = taken;
    end
    if (!rst_n) begin
      exp_btb_pc = m_pc;        exp_btb_stall = 1'b1;
    end else if (c_red) begin
      exp_btb_pc = c_win_pc;    exp_btb_stall = 1'b0;
    end else if (c_fire) begin
      exp_btb_pc = c_next_pc;   exp_btb_stall = 1'b0;
    end else begin
      exp_btb_pc = m_pc;        exp_btb_stall = 1'b1;
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
    end else if (c_red) begin
      m_q.delete();
      m_pc = c_win_pc;
      m_pred = c_win_pred;
      m_halt = 0;
    end else begin
      if (c_deq) void'(m_q.pop_front());
      if (c_fire) begin
        m_q.push_back(c_ent);
        if (c_ent.adef) m_halt = 1;
        else begin
          m_pc = c_next_pc;
          m_pred = c_next_pred;
        end
      end
    end
  endtask

  // Move to the sampling point (negedge) and evaluate the model for this cycle.
  task automatic half();
    @(negedge clk);
    model_comb();
  endtask

  // Complete the cycle: clock edge, model update, then inputs may change.
  task automatic adv();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0;
    redir_valid = '0;
    redir_pc = '0;
    redir_is_pred = '0;
    btb_valid = 1'b0;
    btb_npc = '0;
    btb_lane = '0;
  endtask

  task automatic redirect0(input logic [31:0] pc);
    redir_valid = 3'b001;
    redir_pc = '0;
    redir_pc[31:0] = pc;
    redir_is_pred = '0;
    half();
    adv();
    redir_valid = '0;
  endtask

  task automatic test_reset();
    logic [31:0] want;
    rst_n = 1'b0;
    req_ready = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    half();
    n_total++;
    if (req_valid !== 1'b0 || req_pc !== 32'h0 || req_mask !== '0)
      $display("FAIL reset_req: valid=%b pc=%h mask=%b want 0/0/0", req_valid, req_pc, req_mask);
    else n_pass++;
    n_total++;
    if (btb_pc !== RESET_PC)
      $display("FAIL reset_btb_pc: got %h want %h", btb_pc, RESET_PC);
    else n_pass++;
    adv();
    rst_n = 1'b1;
    half();
    n_total++;
    if (req_valid !== 1'b0) $display("FAIL first_cycle_empty: got %b want 0", req_valid);
    else n_pass++;
    adv();
    for (int k = 0; k < 3; k++) begin
      half();
      want = RESET_PC + 32'(8 * k);
      n_total++;
      if (req_valid !== 1'b1 || req_pc !== want || req_mask !== 2'b11 || req_is_pred !== 1'b0)
        $display("FAIL seq_head%0d: v=%b pc=%h m=%b p=%b want 1/%h/11/0",
                 k, req_valid, req_pc, req_mask, req_is_pred, want);
      else n_pass++;
      adv();
    end
  endtask

  task automatic test_redirect();
    int waited;
    redir_valid = 3'b001;
    redir_pc = '0;
    redir_pc[31:0] = 32'h1c000104;
    half();
    n_total++;
    if (btb_pc !== 32'h1c000104 || btb_stall !== 1'b0)
      $display("FAIL redir_btb: pc=%h stall=%b want 1c000104/0", btb_pc, btb_stall);
    else n_pass++;
    adv();
    redir_valid = '0;
    waited = 0;
    half();
    while (!req_valid && waited < 4) begin
      adv(); half(); waited++;
    end
    n_total++;
    if (req_valid !== 1'b1 || req_pc !== 32'h1c000104 || req_mask !== 2'b10)
      $display("FAIL redir_head: v=%b pc=%h m=%b want 1/1c000104/10", req_valid, req_pc, req_mask);
    else n_pass++;
    adv();
    half();
    n_total++;
    if (req_pc !== 32'h1c000108 || req_mask !== 2'b11 || req_is_pred !== 1'b0)
      $display("FAIL redir_next: pc=%h m=%b p=%b want 1c000108/11/0", req_pc, req_mask, req_is_pred);
    else n_pass++;
    adv();
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    req_ready = 1'b0;
    redirect0(32'h1c000200);
    for (int k = 0; k < 6; k++) begin half(); adv(); end
    half();
    n_total++;
    if (btb_pc !== 32'h1c000220 || btb_stall !== 1'b1)
      $display("FAIL full_hold: btb_pc=%h stall=%b want 1c000220/1", btb_pc, btb_stall);
    else n_pass++;
    n_total++;
    if (req_valid !== 1'b1 || req_pc !== 32'h1c000200)
      $display("FAIL full_head: v=%b pc=%h want 1/1c000200", req_valid, req_pc);
    else n_pass++;
    adv();
    req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      half();
      want = 32'h1c000200 + 32'(8 * k);
      n_total++;
      if (req_valid !== 1'b1 || req_pc !== want)
        $display("FAIL drain%0d: v=%b pc=%h want 1/%h", k, req_valid, req_pc, want);
      else n_pass++;
      adv();
    end
  endtask

  task automatic test_redir_full();
    req_ready = 1'b0;
    redirect0(32'h1c000300);
    for (int k = 0; k < 6; k++) begin half(); adv(); end
    redir_valid = 3'b110;
    redir_pc = '0;
    redir_pc[31:0]  = 32'hdead0000;
    redir_pc[63:32] = 32'h00000100;
    redir_pc[95:64] = 32'h00000200;
    half();
    n_total++;
    if (btb_pc !== 32'h00000100)
      $display("FAIL prio_btb: got %h want 00000100", btb_pc);
    else n_pass++;
    adv();
    redir_valid = '0;
    req_ready = 1'b1;
    half();
    n_total++;
    if (req_valid !== 1'b0) $display("FAIL flushed: v=%b want 0", req_valid);
    else n_pass++;
    adv();
    half();
    n_total++;
    if (req_valid !== 1'b1 || req_pc !== 32'h00000100 || req_mask !== 2'b11)
      $display("FAIL prio_head: v=%b pc=%h m=%b want 1/00000100/11", req_valid, req_pc, req_mask);
    else n_pass++;
    adv();
  endtask

  task automatic test_btb();
    req_ready = 1'b1;
    redirect0(32'h1c000000);
    btb_valid = 1'b1;
    btb_lane = '0;
    btb_npc = 32'h1c000400;
    half();
    n_total++;
    if (btb_pc !== 32'h1c000400) $display("FAIL btb_npc: got %h want 1c000400", btb_pc);
    else n_pass++;
    adv();
    btb_valid = 1'b0;
    half();
    n_total++;
    if (req_valid !== 1'b1 || req_pc !== 32'h1c000000 || req_mask !== 2'b01 || req_is_pred !== 1'b0)
      $display("FAIL btb_group: v=%b pc=%h m=%b p=%b want 1/1c000000/01/0",
               req_valid, req_pc, req_mask, req_is_pred);
    else n_pass++;
    adv();
    half();
    n_total++;
    if (req_valid !== 1'b1 || req_pc !== 32'h1c000400 || req_is_pred !== 1'b1)
      $display("FAIL btb_target: v=%b pc=%h p=%b want 1/1c000400/1", req_valid, req_pc, req_is_pred);
    else n_pass++;
    adv();
  endtask

  task automatic test_adef();
    int waited;
    int stray;
    req_ready = 1'b1;
    redirect0(32'h1c000002);
    half(); adv();
    half();
    n_total++;
    if (req_valid !== 1'b1 || req_adef !== 1'b1 || req_mask !== 2'b00 || req_pc !== 32'h1c000002)
      $display("FAIL adef_head: v=%b adef=%b m=%b pc=%h want 1/1/00/1c000002",
               req_valid, req_adef, req_mask, req_pc);
    else n_pass++;
    adv();
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      half();
      if (req_valid !== 1'b0) stray++;
      adv();
    end
    n_total++;
    if (stray != 0) $display("FAIL halt_quiet: %0d valid cycles want 0", stray);
    else n_pass++;
    redirect0(32'h1c000020);
    waited = 0;
    half();
    while (!req_valid && waited < 4) begin
      adv(); half(); waited++;
    end
    n_total++;
    if (req_valid !== 1'b1 || req_pc !== 32'h1c000020 || req_adef !== 1'b0)
      $display("FAIL halt_exit: v=%b pc=%h adef=%b want 1/1c000020/0", req_valid, req_pc, req_adef);
    else n_pass++;
    adv();
  endtask

  task automatic test_async_reset();
    req_ready = 1'b0;
    redirect0(32'h1c000500);
    for (int k = 0; k < 3; k++) begin half(); adv(); end
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (req_valid !== 1'b0 || btb_pc !== RESET_PC)
      $display("FAIL async_reset: v=%b btb_pc=%h want 0/%h", req_valid, btb_pc, RESET_PC);
    else n_pass++;
    model_reset();
    half(); adv();
    rst_n = 1'b1;
    req_ready = 1'b1;
    half(); adv();
    half();
    n_total++;
    if (req_valid !== 1'b1 || req_pc !== RESET_PC)
      $display("FAIL post_reset_head: v=%b pc=%h want 1/%h", req_valid, req_pc, RESET_PC);
    else n_pass++;
    adv();
  endtask

  task automatic test_random();
    int bad;
    logic [31:0] pc_rand;
    bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle_inputs();
      stall_i   = ($urandom_range(0, 4) == 0);
      req_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) redir_valid = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        pc_rand = ($urandom_range(0, 7) == 0) ? 32'hfffffff0 + 32'($urandom_range(0, 15))
                                              : 32'h1c000000 + 32'($urandom_range(0, 255) * 4);
        if ($urandom_range(0, 9) == 0) pc_rand[1:0] = 2'($urandom_range(1, 3));
        redir_pc[32*i +: 32] = pc_rand;
      end
      redir_is_pred = NR'($urandom);
      btb_valid = ($urandom_range(0, 3) == 0);
      btb_lane  = LANE_W'($urandom_range(0, FW - 1));
      btb_npc   = 32'h1c000000 + 32'($urandom_range(0, 1023) * 4);
      half();
      n_total++;
      if (req_valid !== (m_q.size() > 0)) begin
        $display("FAIL rnd_valid c%0d: got %b want %b", cyc, req_valid, m_q.size() > 0);
        bad++;
      end else n_pass++;
      if (m_q.size() > 0) begin
        n_total++;
        if (req_pc !== m_q[0].pc || req_mask !== m_q[0].mask ||
            req_is_pred !== m_q[0].pred || req_adef !== m_q[0].adef) begin
          $display("FAIL rnd_head c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", cyc,
                   req_pc, req_mask, req_is_pred, req_adef,
                   m_q[0].pc, m_q[0].mask, m_q[0].pred, m_q[0].adef);
          bad++;
        end else n_pass++;
      end
      n_total++;
      if (btb_pc !== exp_btb_pc || btb_stall !== exp_btb_stall) begin
        $display("FAIL rnd_btb c%0d: got %h/%b want %h/%b", cyc, btb_pc, btb_stall,
                 exp_btb_pc, exp_btb_stall);
        bad++;
      end else n_pass++;
      adv();
      if (bad > 20) break;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_backpressure();
    test_redir_full();
    test_btb();
    test_adef();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
